// File: rtl/wb_sram_bridge_pkg.sv
// Shared types and default parameters for the Wishbone-to-OpenRAM bridge.
package wb_sram_bridge_pkg;

    localparam int          DEFAULT_DATA_WIDTH = 32;
    localparam int          DEFAULT_ADDR_WIDTH = 8;
    localparam int          DEFAULT_NUM_WMASKS = DEFAULT_DATA_WIDTH / 8;
    localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h3000_0000;
    localparam logic [31:0] DEFAULT_ADDR_MASK  = 32'hFFFF_FC00;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK,
        ERR
    } state_t;

endpackage

// File: rtl/wb_sram_addr_decode.sv
// Combinational window decode: hit test, alignment check and SRAM word address.
module wb_sram_addr_decode
    import wb_sram_bridge_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK  = DEFAULT_ADDR_MASK
) (
    input  logic                  cyc,
    input  logic                  stb,
    input  logic [31:0]           adr,
    output logic                  hit,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] word_addr
);

    always_comb begin
        hit        = cyc & stb & ((adr & ADDR_MASK) == BASE_ADDR);
        misaligned = (adr[1:0] != 2'b00);
        word_addr  = adr[ADDR_WIDTH+1:2];
    end

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone B4 classic slave driving port 0 (RW) of a byte-masked OpenRAM macro.
// Optional error response for misses/misaligned accesses: define WB_SRAM_BRIDGE_ERR_EN.
module wb_sram_bridge
    import wb_sram_bridge_pkg::*;
#(
    parameter int          DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int          NUM_WMASKS = DEFAULT_NUM_WMASKS,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK  = DEFAULT_ADDR_MASK
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [NUM_WMASKS-1:0] wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef WB_SRAM_BRIDGE_ERR_EN
    ,
    output logic                  wbs_err_o
`endif
);

    state_t                state;
    logic                  hit;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] word_addr;

    wb_sram_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_MASK  (ADDR_MASK)
    ) u_decode (
        .cyc        (wbs_cyc_i),
        .stb        (wbs_stb_i),
        .adr        (wbs_adr_i),
        .hit        (hit),
        .misaligned (misaligned),
        .word_addr  (word_addr)
    );

`ifndef WB_SRAM_BRIDGE_ERR_EN
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
`ifdef WB_SRAM_BRIDGE_ERR_EN
            wbs_err_o   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef WB_SRAM_BRIDGE_ERR_EN
                    if (wbs_cyc_i && wbs_stb_i && (!hit || misaligned)) begin
                        wbs_err_o <= 1'b1;
                        state     <= ERR;
                    end else
`endif
                    if (hit) begin
                        sram_csb0   <= 1'b0;
                        sram_web0   <= ~wbs_we_i;
                        sram_addr0  <= word_addr;
                        sram_din0   <= wbs_dat_i;
                        sram_wmask0 <= wbs_we_i ? wbs_sel_i : '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The macro latches the command on this edge; deselect it
                    // regardless of whether the master is still there.
                    sram_csb0   <= 1'b1;
                    sram_web0   <= 1'b1;
                    sram_wmask0 <= '0;
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (!sram_web0) begin
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // dout0 settled after the falling edge inside this cycle.
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else begin
                        wbs_dat_o <= sram_dout0;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    wbs_ack_o <= 1'b0;
                    state     <= IDLE;
                end
`ifdef WB_SRAM_BRIDGE_ERR_EN
                ERR: begin
                    wbs_err_o <= 1'b0;
                    state     <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Self-checking bench for wb_sram_bridge with a behavioural SRAM and a word-level reference memory.
module tb_wb_sram_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_FC00;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0, dout0;
`ifdef WB_SRAM_BRIDGE_ERR_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    wb_sram_bridge dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .sram_csb0   (csb0),
        .sram_web0   (web0),
        .sram_wmask0 (wmask0),
        .sram_addr0  (addr0),
        .sram_din0   (din0),
        .sram_dout0  (dout0)
`ifdef WB_SRAM_BRIDGE_ERR_EN
        ,
        .wbs_err_o   (err)
`endif
    );

    // Behavioural OpenRAM port 0: capture on rise, read data appears after the fall.
    logic [31:0] sram_mem [256];
    logic [7:0]  rd_addr;
    logic        rd_pend = 1'b0;

    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) sram_mem[addr0][8*b +: 8] <= din0[8*b +: 8];
                rd_pend <= 1'b0;
            end else begin
                rd_addr <= addr0;
                rd_pend <= 1'b1;
            end
        end else begin
            rd_pend <= 1'b0;
        end
    end

    always @(negedge clk) dout0 <= rd_pend ? sram_mem[rd_addr] : $urandom;

    // Reference model: plain word array plus the expected bus read register.
    logic [31:0] ref_mem [256];
    logic [31:0] ref_dat;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
    endtask

    // One bus transaction, observed for up to 16 cycles; entered and left at #1 after a rising edge.
    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold);
        bit  in_win, valid, expect_err;
        int  ack_cyc, n_ack, n_csb, csb_cyc, err_cyc, n_err, drop_at;
        logic [7:0] wa;
        in_win = ((a & MASK) == BASE);
        wa     = a[9:2];
`ifdef WB_SRAM_BRIDGE_ERR_EN
        expect_err = !in_win || (a[1:0] != 2'b00);
`else
        expect_err = 1'b0;
`endif
        valid = in_win && !expect_err;
        ack_cyc = 0; n_ack = 0; n_csb = 0; csb_cyc = 0; err_cyc = 0; n_err = 0; drop_at = 0;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_i = d;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == drop_at) bus_idle();
            if (!csb0) begin
                n_csb++;
                if (n_csb == 1) begin
                    csb_cyc = k;
                    check("issue_addr0", {24'h0, addr0}, {24'h0, wa});
                    check("issue_web0", {31'h0, web0}, {31'h0, ~w});
                    check("issue_wmask0", {28'h0, wmask0}, {28'h0, (w ? s : 4'h0)});
                    check("issue_din0", din0, d);
                end
            end
            if (ack) begin
                n_ack++;
                if (ack_cyc == 0) begin
                    ack_cyc = k;
                    if (!w) begin
                        ref_dat = ref_mem[wa];
                        check("read_data", dat_o, ref_dat);
                    end
                    if (hold) drop_at = k + 1; else bus_idle();
                end
            end
`ifdef WB_SRAM_BRIDGE_ERR_EN
            if (err) begin
                n_err++;
                if (err_cyc == 0) begin
                    err_cyc = k;
                    check("err_no_ack", {31'h0, ack}, 32'h0);
                    bus_idle();
                end
            end
`endif
        end
        bus_idle();
        if (valid) begin
            check("ack_latency", ack_cyc, w ? 2 : 3);
            check("ack_count", n_ack, 1);
            check("csb_cycles", n_csb, 1);
            check("csb_cycle_no", csb_cyc, 1);
            if (w) ref_mem[wa] = merge(ref_mem[wa], d, s);
            check("dat_o_hold", dat_o, ref_dat);
        end else begin
            check("miss_no_ack", n_ack, 0);
            check("miss_no_csb", n_csb, 0);
`ifdef WB_SRAM_BRIDGE_ERR_EN
            check("err_cycle", err_cyc, 1);
            check("err_count", n_err, 1);
`endif
        end
    endtask

    initial begin
        logic [31:0] a, d;
        bit          w;
        int          mode;

        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        ref_dat = 32'h0;
        bus_idle();

        // Reset, then idle outputs until the first strobe
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_web0", {31'h0, web0}, 32'h1);
        check("rst_wmask0", {28'h0, wmask0}, 32'h0);
        check("rst_addr0", {24'h0, addr0}, 32'h0);
        check("rst_din0", din0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("idle_csb0", {31'h0, csb0}, 32'h1);
            check("idle_ack", {31'h0, ack}, 32'h0);
            check("idle_dat_o", dat_o, 32'h0);
        end

        // Full-word write and read back
        xact(1'b1, 32'h3000_0010, 32'hDEADBEEF, 4'hF, 1'b0);
        xact(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0);
        check("t2_data", dat_o, 32'hDEADBEEF);

        // Partial byte write
        xact(1'b1, 32'h3000_0010, 32'h11223344, 4'b0101, 1'b0);
        xact(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0);
        check("t3_data", dat_o, 32'hDE22BE44);

        // Top and bottom of the window, strobe held through ack
        xact(1'b0, 32'h3000_03FC, 32'h0, 4'hF, 1'b1);
        xact(1'b1, 32'h3000_0000, 32'hA5A5_0F0F, 4'hF, 1'b1);
        xact(1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'h0, 1'b0);
        xact(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0);
        check("sel0_data", dat_o, 32'hA5A5_0F0F);

        // Reset while a read sits in WAIT
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_idle();
        ref_dat = 32'h0;
        check("rst_mid_ack", {31'h0, ack}, 32'h0);
        check("rst_mid_dat_o", dat_o, 32'h0);
        check("rst_mid_csb0", {31'h0, csb0}, 32'h1);
        @(posedge clk); #1;
        check("rst_after_ack", {31'h0, ack}, 32'h0);
        xact(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0);
        check("rst_reread", dat_o, 32'hDE22BE44);

        // Master abandons a write while it is being issued: memory still updates, no ack
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0020; dat_i = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus_idle();
        ref_mem[8] = 32'h0BAD_F00D;
        begin
            int acks;
            acks = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (ack) acks++;
            end
            check("abort_no_ack", acks, 0);
        end
        xact(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b0);

        // Out-of-window and misaligned accesses
        xact(1'b0, 32'h3000_0400, 32'h0, 4'hF, 1'b0);
        xact(1'b1, 32'h3000_0400, 32'h1234_5678, 4'hF, 1'b0);
        xact(1'b0, 32'h3000_0002, 32'h0, 4'hF, 1'b0);

        // Randomised traffic
        for (int t = 0; t < 80; t++) begin
            mode = $urandom_range(0, 9);
            w    = 1'($urandom_range(0, 1));
            d    = $urandom;
            a    = BASE | {22'h0, 8'($urandom), 2'b00};
            if (mode == 0) a = $urandom;
            else if (mode == 1) a = a | {30'h0, 2'($urandom_range(1, 3))};
            xact(w, a, d, 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
